// File: rtl/tohost_responder.sv
// End-of-test TOHOST responder: latches the first riscv-tests result word,
// reports done/pass/fail_code, and runs a cycle watchdog while the test is live.
module tohost_responder #(
   parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
   parameter int unsigned TIMEOUT_CYCLES = 10000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        done,
   output logic        pass,
   output logic [30:0] fail_code,
   output logic        timeout,
   output logic [31:0] cycle_cnt
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TIMEOUT
   } state_t;

   localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] tohost_q;
   logic [31:0] read_data;
   logic        accept;
   logic        hit;
   logic        sel_cycle;
   logic        tohost_wr;
   logic        result_wr;
   logic        tohost_load;
   logic        cnt_en;
   logic        unused_addr_lsb;

   // Byte offset within a word does not affect decode.
   assign unused_addr_lsb = ^req_addr[1:0];

   assign req_ready = !rsp_valid || rsp_ready;
   assign accept    = req_valid && req_ready;
   assign hit       = (req_addr[31:3] == TOHOST_ADDR[31:3]);
   assign sel_cycle = req_addr[2];
   assign tohost_wr = accept && req_we && hit && !sel_cycle && (req_be == 4'hF);
   assign result_wr = tohost_wr && req_wdata[0];

   // NOTE: every signal driven here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d     = state_q;
      tohost_load = 1'b0;
      if (state_q == ST_RUN) begin
         tohost_load = tohost_wr;
         // A result write beats the watchdog in the same cycle.
         if (result_wr) begin
            state_d = (req_wdata == 32'h1) ? ST_PASS : ST_FAIL;
         end else if (cycle_cnt == CNT_LAST) begin
            state_d = ST_TIMEOUT;
         end
      end
   end

   // The counter stops on the edge that leaves RUN, so it reads the cycle of the result.
   assign cnt_en = (state_q == ST_RUN) && (state_d == ST_RUN) && (cycle_cnt != CNT_MAX);

   always_comb begin
      read_data = 32'h0;
      if (hit && !req_we) begin
         read_data = sel_cycle ? cycle_cnt : tohost_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tohost_q  <= 32'h0;
         cycle_cnt <= 32'h0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_code <= 31'h0;
         timeout   <= 1'b0;
      end else begin
         if (tohost_load) begin
            tohost_q <= req_wdata;
         end
         if (cnt_en) begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end
         if (state_q == ST_RUN) begin
            done    <= (state_d != ST_RUN);
            pass    <= (state_d == ST_PASS);
            timeout <= (state_d == ST_TIMEOUT);
            if (state_d == ST_FAIL) begin
               fail_code <= req_wdata[31:1];
            end
         end
      end
   end

   // Response register only loads on accept, which keeps it stable while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= read_data;
         rsp_err   <= !hit;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tohost_responder.sv
// Self-checking bench for tohost_responder: directed end-of-test scenarios plus
// randomized bus traffic, scored against a cycles-since-reset reference model.
module tb_tohost_responder;

   localparam logic [31:0] TOHOST     = 32'h8000_1000;
   localparam int unsigned TB_TIMEOUT = 50;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        done;
   logic        pass;
   logic [30:0] fail_code;
   logic        timeout;
   logic [31:0] cycle_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: outcome 0 = running, 1 = pass, 2 = fail, 3 = timeout.
   int unsigned elapsed;
   int unsigned end_cycle;
   int          outcome;
   logic [31:0] m_tohost;
   logic [30:0] m_fail;
   logic        m_pending;
   rsp_t        exp_q[$];

   tohost_responder #(
      .TOHOST_ADDR   (TOHOST),
      .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .req_be   (req_be),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .done     (done),
      .pass     (pass),
      .fail_code(fail_code),
      .timeout  (timeout),
      .cycle_cnt(cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_cnt();
      return (outcome != 0) ? end_cycle : elapsed;
   endfunction

   task automatic model_reset();
      elapsed   = 0;
      end_cycle = 0;
      outcome   = 0;
      m_tohost  = 32'h0;
      m_fail    = 31'h0;
      m_pending = 1'b0;
      exp_q.delete();
   endtask

   task automatic check_status();
      check("done",      done,      32'(outcome != 0));
      check("pass",      pass,      32'(outcome == 1));
      check("timeout",   timeout,   32'(outcome == 3));
      check("fail_code", fail_code, 32'(m_fail));
      check("cycle_cnt", cycle_cnt, model_cnt());
      check("rsp_valid", rsp_valid, 32'(m_pending));
   endtask

   // One clock: drive at the falling edge, predict the rising edge, return 1 after it.
   task automatic cycle(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic rr);
      logic acc;
      logic m_hit;
      rsp_t e;
      @(negedge clk);
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      req_be    = be;
      rsp_ready = rr;
      #1;
      check_status();
      check("req_ready", req_ready, 32'(!m_pending || rr));
      acc   = v && (!m_pending || rr);
      m_hit = ((a >> 3) == (TOHOST >> 3));
      if (acc) begin
         e.err   = !m_hit;
         e.rdata = 32'h0;
         if (m_hit && !we) e.rdata = a[2] ? model_cnt() : m_tohost;
         exp_q.push_back(e);
         if (outcome == 0 && m_hit && we && !a[2] && be == 4'hF) begin
            m_tohost = wd;
            if (wd[0]) begin
               outcome   = (wd == 32'h1) ? 1 : 2;
               end_cycle = elapsed;
               if (wd != 32'h1) m_fail = wd[31:1];
            end
         end
      end
      if (outcome == 0 && elapsed == TB_TIMEOUT - 1) begin
         outcome   = 3;
         end_cycle = elapsed;
      end
      elapsed++;
      m_pending = acc ? 1'b1 : (rr ? 1'b0 : m_pending);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_be    = 4'h0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      check("rst_done",      done,      32'h0);
      check("rst_pass",      pass,      32'h0);
      check("rst_fail_code", fail_code, 32'h0);
      check("rst_timeout",   timeout,   32'h0);
      check("rst_cycle_cnt", cycle_cnt, 32'h0);
      check("rst_rsp_valid", rsp_valid, 32'h0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err",   rsp_err,   32'h0);
      rst_n = 1'b1;
   endtask

   // Monitor: scores every completed response handshake and checks stall stability.
   initial begin : monitor
      rsp_t        e;
      logic        held;
      logic [31:0] h_rdata;
      logic        h_err;
      held = 1'b0;
      h_rdata = 32'h0;
      h_err = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("hold_valid", rsp_valid, 32'h1);
               check("hold_rdata", rsp_rdata, h_rdata);
               check("hold_err",   rsp_err,   32'(h_err));
            end
            if (rsp_valid && rsp_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL rsp_unexpected: got rdata %h err %0b with nothing expected", rsp_rdata, rsp_err);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_rdata", rsp_rdata, e.rdata);
                  check("rsp_err",   rsp_err,   32'(e.err));
               end
            end
            held    = rsp_valid && !rsp_ready;
            h_rdata = rsp_rdata;
            h_err   = rsp_err;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL sim_timeout: simulation did not finish within the time limit");
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      int          r;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_be    = 4'h0;
      rsp_ready = 1'b1;
      model_reset();

      // Pass at cycle 10, counter freezes, result readable.
      do_reset();
      idle(10);
      cycle(1'b1, 1'b1, TOHOST, 32'h1, 4'hF, 1'b1);
      check("pass_done", done, 32'h1);
      check("pass_pass", pass, 32'h1);
      check("pass_fail_code", fail_code, 32'h0);
      check("pass_cnt", cycle_cnt, 32'd10);
      idle(5);
      check("pass_cnt_frozen", cycle_cnt, 32'd10);
      cycle(1'b1, 1'b0, TOHOST, 32'h0, 4'hF, 1'b1);
      cycle(1'b1, 1'b0, TOHOST + 32'h4, 32'h0, 4'hF, 1'b1);

      // Reset from PASS clears everything and restarts the counter.
      do_reset();
      idle(3);
      check("restart_cnt", cycle_cnt, 32'd3);

      // Fail code, then a later pass write is ignored.
      cycle(1'b1, 1'b1, TOHOST, 32'h7, 4'hF, 1'b1);
      check("fail_done", done, 32'h1);
      check("fail_pass", pass, 32'h0);
      check("fail_code", fail_code, 32'd3);
      cycle(1'b1, 1'b1, TOHOST, 32'h1, 4'hF, 1'b1);
      idle(1);
      check("fail_sticky_pass", pass, 32'h0);
      check("fail_sticky_code", fail_code, 32'd3);
      cycle(1'b1, 1'b0, TOHOST, 32'h0, 4'hF, 1'b1);

      // Watchdog with no writes.
      do_reset();
      idle(TB_TIMEOUT);
      check("to_timeout", timeout, 32'h1);
      check("to_done", done, 32'h1);
      check("to_cnt", cycle_cnt, TB_TIMEOUT - 1);

      // Result write on the timeout cycle wins.
      do_reset();
      idle(TB_TIMEOUT - 1);
      cycle(1'b1, 1'b1, TOHOST, 32'h1, 4'hF, 1'b1);
      check("race_pass", pass, 32'h1);
      check("race_timeout", timeout, 32'h0);
      check("race_cnt", cycle_cnt, TB_TIMEOUT - 1);

      // Stalled response: req_ready low, data held, a blocked request is not taken.
      do_reset();
      cycle(1'b1, 1'b1, TOHOST, 32'h8, 4'hF, 1'b1);
      cycle(1'b1, 1'b0, TOHOST + 32'h4, 32'h0, 4'hF, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, TOHOST, 32'h1, 4'hF, 1'b0);
         check("stall_req_ready", req_ready, 32'h0);
      end
      check("stall_done", done, 32'h0);
      cycle(1'b1, 1'b0, TOHOST, 32'h0, 4'hF, 1'b1);

      // Misses, partial writes and CYCLE-word writes change nothing.
      cycle(1'b1, 1'b1, 32'h8000_2000, 32'h1, 4'hF, 1'b1);
      cycle(1'b1, 1'b0, 32'h8000_2000, 32'h0, 4'hF, 1'b1);
      cycle(1'b1, 1'b1, TOHOST, 32'h1, 4'h3, 1'b1);
      cycle(1'b1, 1'b1, TOHOST + 32'h4, 32'h1, 4'hF, 1'b1);
      idle(1);
      check("ignored_done", done, 32'h0);
      cycle(1'b1, 1'b0, TOHOST, 32'h0, 4'hF, 1'b1);

      // Randomized episodes.
      for (int ep = 0; ep < 10; ep++) begin
         do_reset();
         for (int i = 0; i < 120; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
               0, 1, 2, 3: a = TOHOST;
               4, 5:       a = TOHOST + 32'h4;
               6:          a = TOHOST + $urandom_range(0, 7);
               7:          a = 32'h8000_2000;
               8:          a = $urandom;
               default:    a = TOHOST ^ (32'h8 << $urandom_range(0, 28));
            endcase
            r = int'($urandom_range(0, 9));
            if (r == 0)      wd = 32'h1;
            else if (r < 3)  wd = $urandom | 32'h1;
            else             wd = $urandom & 32'hFFFF_FFFE;
            be = ($urandom_range(0, 4) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1, a, wd, be,
                  ($urandom_range(0, 3) != 0));
         end
      end

      // Drain and confirm every accepted request got its response.
      idle(3);
      check("drain_queue", exp_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
